// File: rtl/apb_wait_slave.sv
// APB target with a small register bank and a programmable wait-state count.
// Used as the default slave behind the AHB-to-APB bridge to exercise wait, OK and error paths.
module apb_wait_slave #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 32,
    parameter logic [3:0]        WAIT_RESET = 4'd2,
    parameter logic [DATA_W-1:0] ID_VALUE   = 32'hA5B0_0001
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] prdata
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic [ADDR_W-1:2]   addr_reg;
    logic                write_reg;
    logic                err_reg;
    logic [DATA_W-1:0]   wdata_reg;

    logic [3:0]          ctrl_reg;
    logic [DATA_W-1:0]   scratch_reg [4];
    logic [15:0]         wcnt_reg;
    logic [7:0]          errcnt_reg;

    logic                pready_reg, pready_next;
    logic                pslverr_reg, pslverr_next;
    logic [DATA_W-1:0]   prdata_reg, prdata_next;

    logic                setup;
    logic                complete;
    logic                setup_err;
    logic [ADDR_W-1:2]   cur_addr;
    logic [2:0]          cur_idx;
    logic                cur_err;
    logic                cur_write;
    logic [DATA_W-1:0]   rd_data;
    logic                commit_ok;
    logic [3:0]          scratch_we;

    // penable is not needed: any selected cycle in IDLE is taken as setup.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, penable, paddr[1:0]};

    assign setup    = (state_reg == IDLE) && psel;
    assign complete = (state_reg == ACCESS) && (cnt_reg == 4'd0);

    assign setup_err = (paddr[ADDR_W-1:5] != '0) || (pwrite && (paddr[4:2] >= 3'd5));

    // In IDLE the transfer being set up is decoded straight from the bus so that
    // a zero-wait read can present data on the very next cycle.
    assign cur_addr  = (state_reg == IDLE) ? paddr[ADDR_W-1:2] : addr_reg;
    assign cur_idx   = cur_addr[4:2];
    assign cur_err   = (state_reg == IDLE) ? setup_err : err_reg;
    assign cur_write = (state_reg == IDLE) ? pwrite : write_reg;

    always_comb begin
        rd_data = '0;
        case (cur_idx)
            3'd0:    rd_data = DATA_W'(ctrl_reg);
            3'd5:    rd_data = ID_VALUE;
            3'd6:    rd_data = DATA_W'(wcnt_reg);
            3'd7:    rd_data = DATA_W'(errcnt_reg);
            default: rd_data = scratch_reg[cur_idx[1:0] - 2'd1];
        endcase
    end

    assign commit_ok = complete && write_reg && !err_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_scratch_we
        assign scratch_we[gi] = commit_ok && (addr_reg[4:2] == 3'(gi + 1));
    end

    // State register
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (psel) begin
                    state_next = ACCESS;
                    cnt_next   = ctrl_reg;
                end
            end
            ACCESS: begin
                if (cnt_reg == 4'd0 || !psel) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: decided one edge early so the outputs come straight from flops.
    always_comb begin
        pready_next  = 1'b0;
        pslverr_next = 1'b0;
        prdata_next  = '0;
        if (setup && ctrl_reg == 4'd0)
            pready_next = 1'b1;
        if (state_reg == ACCESS && psel && cnt_reg == 4'd1)
            pready_next = 1'b1;
        if (pready_next) begin
            pslverr_next = cur_err;
            if (!cur_err && !cur_write)
                prdata_next = rd_data;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            prdata_reg  <= '0;
            addr_reg    <= '0;
            write_reg   <= 1'b0;
            err_reg     <= 1'b0;
            wdata_reg   <= '0;
        end else begin
            pready_reg  <= pready_next;
            pslverr_reg <= pslverr_next;
            prdata_reg  <= prdata_next;
            if (setup) begin
                addr_reg  <= paddr[ADDR_W-1:2];
                write_reg <= pwrite;
                err_reg   <= setup_err;
                wdata_reg <= pwdata;
            end
        end
    end

    // Register bank
    always_ff @(posedge hclk) begin
        if (hreset) begin
            ctrl_reg   <= WAIT_RESET;
            wcnt_reg   <= '0;
            errcnt_reg <= '0;
            for (int i = 0; i < 4; i++)
                scratch_reg[i] <= '0;
        end else begin
            if (commit_ok && addr_reg[4:2] == 3'd0)
                ctrl_reg <= wdata_reg[3:0];
            for (int i = 0; i < 4; i++)
                if (scratch_we[i])
                    scratch_reg[i] <= wdata_reg;
            if (commit_ok)
                wcnt_reg <= wcnt_reg + 16'd1;
            if (complete && err_reg && errcnt_reg != 8'hFF)
                errcnt_reg <= errcnt_reg + 8'd1;
        end
    end

    assign pready  = pready_reg;
    assign pslverr = pslverr_reg;
    assign prdata  = prdata_reg;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench for apb_wait_slave: timing of pready per wait-state setting,
// register behaviour, error responses, abort and mid-transfer reset.
module tb_apb_wait_slave;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int passes = 0;
    int total  = 0;

    int          cyc;
    logic        err;
    logic [31:0] rd;

    localparam logic [31:0] ID = 32'hA5B0_0001;

    apb_wait_slave dut (
        .hclk    (hclk),
        .hreset  (hreset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pready  (pready),
        .pslverr (pslverr),
        .prdata  (prdata)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge; leaves at the negedge after the completion cycle.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        output int c, output logic e, output logic [31:0] r);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        c = 0; e = 1'b0; r = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge hclk);
            penable = 1'b1;
            if (pready) begin
                c = n; e = pslverr; r = prdata;
                break;
            end
            if (pslverr) begin
                c = -1;
                break;
            end
        end
        @(negedge hclk);
        psel = 1'b0; penable = 1'b0;
        $display("xfer %s addr=%h wdata=%h -> cycles=%0d err=%0b rdata=%h",
                 wr ? "WR" : "RD", a, d, c, e, r);
    endtask

    initial begin
        hreset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (2) @(negedge hclk);
        check("rst_pready", {31'b0, pready}, 32'd0);
        check("rst_pslverr", {31'b0, pslverr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        hreset = 1'b0;
        @(negedge hclk);

        xfer(1'b0, 8'h00, 32'h0, cyc, err, rd);
        check("rd_ctrl_data", rd, 32'h2);
        check("rd_ctrl_cyc", cyc, 3);
        check("rd_ctrl_err", {31'b0, err}, 32'd0);
        xfer(1'b0, 8'h14, 32'h0, cyc, err, rd);
        check("rd_id_data", rd, ID);
        check("rd_id_cyc", cyc, 3);
        check("rd_id_err", {31'b0, err}, 32'd0);
        xfer(1'b0, 8'h18, 32'h0, cyc, err, rd);
        check("rd_wcnt0", rd, 32'd0);
        check("rd_wcnt0_cyc", cyc, 3);

        xfer(1'b1, 8'h04, 32'hDEADBEEF, cyc, err, rd);
        check("wr_s0_cyc", cyc, 3);
        check("wr_s0_err", {31'b0, err}, 32'd0);
        check("wr_s0_rdata", rd, 32'd0);
        xfer(1'b0, 8'h04, 32'h0, cyc, err, rd);
        check("rd_s0", rd, 32'hDEADBEEF);
        xfer(1'b0, 8'h18, 32'h0, cyc, err, rd);
        check("rd_wcnt1", rd, 32'd1);

        xfer(1'b1, 8'h00, 32'h0, cyc, err, rd);
        check("wr_ctrl0_cyc", cyc, 3);
        xfer(1'b1, 8'h00, 32'hF, cyc, err, rd);
        check("w0_cyc", cyc, 1);
        xfer(1'b0, 8'h00, 32'h0, cyc, err, rd);
        check("w15_cyc", cyc, 16);
        check("rd_ctrl_f", rd, 32'hF);
        xfer(1'b1, 8'h00, 32'hFFFF_FFF2, cyc, err, rd);
        check("wr_ctrl2_cyc", cyc, 16);
        xfer(1'b0, 8'h00, 32'h0, cyc, err, rd);
        check("rd_ctrl_masked", rd, 32'h2);
        check("rd_ctrl2_cyc", cyc, 3);
        xfer(1'b0, 8'h18, 32'h0, cyc, err, rd);
        check("rd_wcnt4", rd, 32'd4);

        xfer(1'b1, 8'h14, 32'h1234, cyc, err, rd);
        check("wr_id_err", {31'b0, err}, 32'd1);
        check("wr_id_rdata", rd, 32'd0);
        check("wr_id_cyc", cyc, 3);
        xfer(1'b0, 8'h40, 32'h0, cyc, err, rd);
        check("rd_unmapped_err", {31'b0, err}, 32'd1);
        check("rd_unmapped_rdata", rd, 32'd0);
        xfer(1'b0, 8'h14, 32'h0, cyc, err, rd);
        check("id_unchanged", rd, ID);
        xfer(1'b0, 8'h1C, 32'h0, cyc, err, rd);
        check("rd_errcnt2", rd, 32'd2);
        xfer(1'b0, 8'h18, 32'h0, cyc, err, rd);
        check("wcnt_after_err", rd, 32'd4);

        // Abort: psel drops in access cycle 1 of a W=2 write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h55;
        @(negedge hclk);
        penable = 1'b1;
        check("abort_ac1_pready", {31'b0, pready}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            check("abort_no_pready", {31'b0, pready}, 32'd0);
        end
        $display("abort WR addr=08 wdata=00000055");
        xfer(1'b0, 8'h08, 32'h0, cyc, err, rd);
        check("abort_s1_zero", rd, 32'd0);
        xfer(1'b0, 8'h18, 32'h0, cyc, err, rd);
        check("abort_wcnt", rd, 32'd4);

        // Back-to-back write then read of SCRATCH3.
        xfer(1'b1, 8'h10, 32'h0BADF00D, cyc, err, rd);
        xfer(1'b0, 8'h10, 32'h0, cyc, err, rd);
        check("b2b_s3", rd, 32'h0BADF00D);
        check("b2b_cyc", cyc, 3);

        // ERRCNT saturation with zero wait states.
        xfer(1'b1, 8'h00, 32'h0, cyc, err, rd);
        for (int i = 0; i < 260; i++) begin
            xfer(1'b1, 8'h1C, 32'h0, cyc, err, rd);
            if (i == 259) begin
                check("sat_err", {31'b0, err}, 32'd1);
                check("sat_cyc", cyc, 1);
            end
        end
        xfer(1'b0, 8'h1C, 32'h0, cyc, err, rd);
        check("errcnt_sat", rd, 32'hFF);
        xfer(1'b0, 8'h18, 32'h0, cyc, err, rd);
        check("wcnt6", rd, 32'd6);

        // Reset in the access phase of a write to SCRATCH2 (W=7).
        xfer(1'b1, 8'h00, 32'h7, cyc, err, rd);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h99;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        hreset = 1'b1;
        @(negedge hclk);
        check("mid_rst_pready", {31'b0, pready}, 32'd0);
        check("mid_rst_pslverr", {31'b0, pslverr}, 32'd0);
        check("mid_rst_prdata", prdata, 32'd0);
        hreset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge hclk);
        $display("reset during WR addr=0c");
        xfer(1'b0, 8'h00, 32'h0, cyc, err, rd);
        check("post_rst_ctrl", rd, 32'h2);
        check("post_rst_cyc", cyc, 3);
        xfer(1'b0, 8'h0C, 32'h0, cyc, err, rd);
        check("post_rst_s2", rd, 32'd0);
        xfer(1'b0, 8'h04, 32'h0, cyc, err, rd);
        check("post_rst_s0", rd, 32'd0);
        xfer(1'b0, 8'h18, 32'h0, cyc, err, rd);
        check("post_rst_wcnt", rd, 32'd0);
        xfer(1'b0, 8'h1C, 32'h0, cyc, err, rd);
        check("post_rst_errcnt", rd, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/apb_wait_slave.md
# apb_wait_slave

- APB target that terminates transfers issued by the AHB-to-APB bridge's APB side (`psel_en`, `paddr`, `penable`, `pwrite`, `pwdata`).
- Returns `pready`, `pslverr` and `prdata` to the bridge.
- Holds a small register bank with a runtime-programmable wait-state count, so the bridge's wait, success and error paths can be exercised from the same design.
- Serves as the default slave instance on the APB segment behind the bridge.

## Interface
Parameters:
- `ADDR_W`, 8: width of `paddr`.
- `DATA_W`, 32: width of `pwdata` and `prdata`.
- `WAIT_RESET`, 2: reset value of CTRL[3:0] (wait states); range 0-15.
- `ID_VALUE`, 32'hA5B0_0001: constant returned by the ID register.

Ports:
- `hclk`, in, 1: system clock, all logic on the rising edge.
- `hreset`, in, 1: reset; one clock; reset is synchronous and active-high.
- `psel`, in, 1: slave select; connects to the bridge's `psel_en`.
- `penable`, in, 1: APB enable (access phase).
- `pwrite`, in, 1: 1 = write, 0 = read.
- `paddr`, in, ADDR_W: byte address; [1:0] ignored.
- `pwdata`, in, DATA_W: write data.
- `pready`, out, 1: transfer-complete strobe.
- `pslverr`, out, 1: error response; valid only while `pready`=1.
- `prdata`, out, DATA_W: read data; valid only while `pready`=1, 0 otherwise.

## Operation
Register map (word index = paddr[4:2]). Any paddr[ADDR_W-1:5] ≠ 0 is unmapped.
- 0x00 CTRL: RW. Bits [3:0] = wait states W, reset WAIT_RESET. Other bits read 0.
- 0x04-0x10 SCRATCH0-3: RW, full width, reset 0.
- 0x14 ID: RO, returns ID_VALUE.
- 0x18 WCNT: RO. [15:0] counts successful writes (including CTRL); wraps 0xFFFF→0. Upper bits read 0.
- 0x1C ERRCNT: RO. [7:0] counts error responses; saturates at 0xFF. Upper bits read 0.

Errors:
- An error is an unmapped address (read or write) or a write to ID, WCNT or ERRCNT.
- Response: `pslverr`=1 with `pready`; `prdata`=0.
- No register changes except ERRCNT, which increments.

State machine, states IDLE, ACCESS:
- IDLE → ACCESS when `psel`=1 and `penable`=0 (setup cycle). On that edge:
  - latch address, direction and pwdata;
  - load wait counter with the current CTRL[3:0];
  - precompute the error flag.
- IDLE with `psel`=1 and `penable`=1 (no setup seen): treated as a setup cycle; the transfer then completes one cycle later than nominal.
- ACCESS: counter decrements each cycle while nonzero.
- Completion cycle: the access cycle in which the counter is 0. In that cycle `pready`=1, `pslverr` = error flag, and `prdata` = read data (reads without error).
- On the edge ending the completion cycle:
  - a write commits;
  - WCNT/ERRCNT update;
  - state returns to IDLE.
- `psel` dropping during ACCESS before completion: abort. Return to IDLE, no commit, no counter update.
- Writes to CTRL affect only transfers whose setup follows the commit edge.

## Timing
- Reset values: `pready`=0, `pslverr`=0, `prdata`=0, state IDLE, CTRL[3:0]=WAIT_RESET, SCRATCH/WCNT/ERRCNT=0.
- Reset asserted mid-transfer: the next edge forces every reset value and the transfer is dropped.
- All three outputs are registered; none depends combinationally on APB inputs.
- Transfer with W wait states: setup cycle + W+1 access cycles. `pready` is high only in the last access cycle.
  - W=0 gives the minimal 2-cycle APB transfer.
  - W=15 gives 17 cycles.
- `pready` is a single-cycle pulse per transfer. `pslverr` is never high while `pready`=0.
- Back-to-back: a setup cycle immediately after the completion cycle is accepted with no idle gap.
- Read data is sampled from register state at the completion cycle. A write committing on the preceding edge is visible.
- Simultaneous events:
  - WCNT increment and CTRL write on the same edge: both take effect.
  - ERRCNT at 0xFF plus an error: stays 0xFF, and `pslverr` is still asserted.

## Test plan
- Reset, then read 0x00, 0x14, 0x18: CTRL=0x2, ID=0xA5B00001, WCNT=0. Each transfer shows `pready` in access cycle 3 (W=2) and `pslverr`=0.
- Write 0x04=0xDEADBEEF, read back: 0xDEADBEEF. WCNT=1 after the write.
- Write CTRL=0, then CTRL=0xF: the next transfer completes in access cycle 1; the one after in access cycle 16.
- Write ID=0x1234 and read 0x40: both give `pslverr`=1 and `prdata`=0. ID unchanged, ERRCNT=2, WCNT unchanged.
- Drop `psel` in access cycle 1 of a W=2 write to 0x08=0x55: no `pready`, SCRATCH1 stays 0.
- Assert `hreset` in the access phase of a write: all outputs 0 next cycle. Register returns its reset value; CTRL reads 0x2.
